// File: rtl/direction_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : direction_input_conditioner
//  Purpose  : Turns four raw active-low push-buttons into a clean snake
//             heading. Each key goes through a 2-flop synchroniser, a
//             debouncer and a press-edge detector. The accepted headings
//             wait in a 2-deep queue and are committed on the datapath's
//             move tick. A 180-degree reversal is never issued.
//  Ports    : clk        - system clock
//             resetn     - asynchronous active-low reset
//             key_n[3:0] - raw keys, active-low ([3]=left [2]=up [1]=down [0]=right)
//             move_tick  - one-cycle advance pulse from the datapath
//             dir[1:0]   - committed heading (00=R 01=D 10=U 11=L)
//             move_*     - one-hot decode of dir
//             press[3:0] - one-cycle debounced press pulses
//             q_count    - number of queued headings (0..2)
//             drop       - one-cycle pulse: a press was rejected
//  Revision : 1.0 - initial release
// ============================================================================
module direction_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] key_n,
   input  logic       move_tick,
   output logic [1:0] dir,
   output logic       move_right,
   output logic       move_down,
   output logic       move_up,
   output logic       move_left,
   output logic [3:0] press,
   output logic [1:0] q_count,
   output logic       drop
);

   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_stable;
   logic [3:0] r_stable_d;
   logic [3:0] r_press;
   logic [1:0] r_q [0:1];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic [1:0] r_dir;
   logic       r_drop;

   logic       w_req_valid;
   logic [1:0] w_req;
   logic [1:0] w_tail;
   logic       w_pop;
   logic       w_accept;

   // Two-flop synchroniser; idle level of an active-low key is 1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 4'b1111;
         r_sync2 <= 4'b1111;
      end else begin
         r_sync1 <= key_n;
         r_sync2 <= r_sync1;
      end
   end

   // Per-key debouncer: the stable value only follows the synchronised
   // value after DEBOUNCE_CYCLES consecutive cycles of disagreement.
   for (genvar k = 0; k < 4; k++) begin : g_key
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
         end else if (r_sync2[k] != r_stable) begin
            if (r_cnt == c_cnt_max) begin
               r_stable <= ~r_stable;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end

      assign w_stable[k] = r_stable;
   end

   // Press pulse on a released(1) -> pressed(0) transition of the stable value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stable_d <= 4'b1111;
         r_press    <= 4'b0000;
      end else begin
         r_stable_d <= w_stable;
         r_press    <= r_stable_d & ~w_stable;
      end
   end

   // Key bit index equals the heading code, so priority right>down>up>left
   // is simply "lowest set bit wins".
   always_comb begin
      w_req_valid = |r_press;
      w_req       = 2'b11;
      if (r_press[0])      w_req = 2'b00;
      else if (r_press[1]) w_req = 2'b01;
      else if (r_press[2]) w_req = 2'b10;
   end

   assign w_pop  = move_tick && (r_count != 2'd0);
   // Acceptance is judged against the pre-pop tail: the newest queued entry,
   // or the committed heading when nothing is queued.
   assign w_tail = (r_count != 2'd0) ? r_q[~r_wr_ptr] : r_dir;
   assign w_accept = w_req_valid
                  && (w_req != w_tail)
                  && ((w_req ^ w_tail) != 2'b11)
                  && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_q[0]   <= 2'b00;
         r_q[1]   <= 2'b00;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_dir    <= 2'b00;
         r_drop   <= 1'b0;
      end else begin
         r_drop <= w_req_valid && !w_accept;
         if (w_accept) begin
            r_q[r_wr_ptr] <= w_req;
            r_wr_ptr      <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_dir    <= r_q[r_rd_ptr];
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign dir        = r_dir;
   assign move_right = (r_dir == 2'b00);
   assign move_down  = (r_dir == 2'b01);
   assign move_up    = (r_dir == 2'b10);
   assign move_left  = (r_dir == 2'b11);
   assign press      = r_press;
   assign q_count    = r_count;
   assign drop       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_direction_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_direction_input_conditioner
//  Purpose  : Self-checking bench for direction_input_conditioner with a
//             short debounce window. A behavioural model (key history,
//             run-length debounce, heading queue) is compared against every
//             DUT output each cycle; directed scenarios add literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_direction_input_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] key_n;
   logic       move_tick;
   logic [1:0] dir;
   logic       move_right, move_down, move_up, move_left;
   logic [3:0] press;
   logic [1:0] q_count;
   logic       drop;

   int checks   = 0;
   int failures = 0;

   logic [3:0] press_seen;
   logic       drop_seen;

   // Behavioural model state
   logic [3:0] m_s1, m_s2, m_stab, m_fell, m_press;
   int         m_run [4];
   logic [1:0] m_dir;
   logic       m_drop;
   logic [1:0] mq [$];

   direction_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .clk(clk), .resetn(resetn), .key_n(key_n), .move_tick(move_tick),
      .dir(dir), .move_right(move_right), .move_down(move_down),
      .move_up(move_up), .move_left(move_left), .press(press),
      .q_count(q_count), .drop(drop)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = 4'hF; m_s2 = 4'hF; m_stab = 4'hF; m_fell = 4'h0; m_press = 4'h0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_dir = 2'b00; m_drop = 1'b0;
      mq.delete();
   endtask

   // One clock edge of the model; all decisions use the pre-edge state.
   task automatic model_edge();
      logic [3:0] n_stab;
      logic [3:0] n_fell;
      int         r;
      int         tail;
      bit         pop, accept, n_drop;
      n_stab = m_stab;
      n_fell = 4'h0;
      for (int k = 0; k < 4; k++) begin
         if (m_s2[k] != m_stab[k]) begin
            m_run[k]++;
            if (m_run[k] == D) begin
               n_stab[k] = ~m_stab[k];
               n_fell[k] = m_stab[k];
               m_run[k]  = 0;
            end
         end else begin
            m_run[k] = 0;
         end
      end
      r = 0;
      for (int k = 3; k >= 0; k--) if (m_press[k]) r = k;
      pop    = move_tick && (mq.size() > 0);
      accept = 0;
      n_drop = 0;
      if (m_press != 4'h0) begin
         tail   = (mq.size() > 0) ? int'(mq[$]) : int'(m_dir);
         accept = (r != tail) && ((r ^ tail) != 3) && (mq.size() < 2 || pop);
         n_drop = !accept;
      end
      if (pop) m_dir = mq.pop_front();
      if (accept) mq.push_back(2'(r));
      m_s2    = m_s1;
      m_s1    = key_n;
      m_stab  = n_stab;
      m_press = m_fell;
      m_fell  = n_fell;
      m_drop  = n_drop;
   endtask

   task automatic check_all();
      chk("dir", int'(dir), int'(m_dir));
      chk("move_right", int'(move_right), int'(m_dir == 2'b00));
      chk("move_down", int'(move_down), int'(m_dir == 2'b01));
      chk("move_up", int'(move_up), int'(m_dir == 2'b10));
      chk("move_left", int'(move_left), int'(m_dir == 2'b11));
      chk("press", int'(press), int'(m_press));
      chk("q_count", int'(q_count), mq.size());
      chk("drop", int'(drop), int'(m_drop));
   endtask

   task automatic step();
      @(posedge clk);
      if (resetn) model_edge();
      #1;
      check_all();
      press_seen = press_seen | press;
      drop_seen  = drop_seen | drop;
   endtask

   task automatic reset_dut();
      resetn = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) step();
      resetn = 1'b1;
   endtask

   task automatic press_keys(input logic [3:0] mask, input int low, input bit tick_on_press,
                             output int lat, output int pulses);
      press_seen = 4'h0;
      drop_seen  = 1'b0;
      lat        = -1;
      pulses     = 0;
      key_n      = ~mask;
      for (int i = 1; i <= low; i++) begin
         step();
         if ((press & mask) != 4'h0) begin
            pulses++;
            if (lat < 0) lat = i;
         end
         move_tick = tick_on_press && ((press & mask) != 4'h0);
      end
      move_tick = 1'b0;
      key_n     = 4'hF;
      repeat (8) step();
   endtask

   task automatic tick();
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
   endtask

   initial begin
      int         lat, pulses;
      logic [3:0] mask;
      int         hold;
      logic       glitch [8];
      key_n      = 4'hF;
      move_tick  = 1'b0;
      press_seen = 4'h0;
      drop_seen  = 1'b0;
      reset_dut();

      // Idle after reset
      repeat (20) step();
      chk("idle_dir", int'(dir), 0);
      chk("idle_move_right", int'(move_right), 1);
      chk("idle_press", int'(press_seen), 0);
      chk("idle_q_count", int'(q_count), 0);

      // Glitchy key never survives the debounce window
      glitch = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      press_seen = 4'h0;
      for (int i = 0; i < 8; i++) begin
         key_n = {1'b1, glitch[i], 2'b11};
         step();
      end
      key_n = 4'hF;
      repeat (10) step();
      chk("glitch_press", int'(press_seen), 0);
      chk("glitch_q_count", int'(q_count), 0);

      // Clean up press: latency 2 + D + 1, one pulse, queued, committed on tick
      press_keys(4'b0100, 10, 1'b0, lat, pulses);
      chk("up_latency", lat, 7);
      chk("up_pulses", pulses, 1);
      chk("up_q_count", int'(q_count), 1);
      tick();
      chk("up_dir_after_tick", int'(dir), 2);
      chk("up_move_up", int'(move_up), 1);

      // Reversal rejected, then two queued headings committed in order
      reset_dut();
      press_keys(4'b1000, 10, 1'b0, lat, pulses);
      chk("rev_drop", int'(drop_seen), 1);
      chk("rev_q_count", int'(q_count), 0);
      press_keys(4'b0100, 10, 1'b0, lat, pulses);
      press_keys(4'b1000, 10, 1'b0, lat, pulses);
      chk("two_q_count", int'(q_count), 2);
      tick();
      chk("first_tick_dir", int'(dir), 2);
      tick();
      chk("second_tick_dir", int'(dir), 3);
      chk("drained_q_count", int'(q_count), 0);

      // Full queue: push together with pop accepted, then a third press drops
      press_keys(4'b0100, 10, 1'b0, lat, pulses);
      press_keys(4'b0001, 10, 1'b0, lat, pulses);
      chk("full_q_count", int'(q_count), 2);
      press_keys(4'b0010, 10, 1'b1, lat, pulses);
      chk("pushpop_q_count", int'(q_count), 2);
      chk("pushpop_dir", int'(dir), 2);
      chk("pushpop_no_drop", int'(drop_seen), 0);
      press_keys(4'b1000, 10, 1'b0, lat, pulses);
      chk("full_drop", int'(drop_seen), 1);
      chk("full_q_count_held", int'(q_count), 2);

      // Simultaneous right+down while heading up: right wins, down silent
      reset_dut();
      press_keys(4'b0100, 10, 1'b0, lat, pulses);
      tick();
      press_keys(4'b0011, 10, 1'b0, lat, pulses);
      chk("multi_q_count", int'(q_count), 1);
      chk("multi_no_drop", int'(drop_seen), 0);
      chk("multi_dir_before_reset", int'(dir), 2);
      resetn = 1'b0;
      model_reset();
      #1;
      chk("midq_reset_q_count", int'(q_count), 0);
      chk("midq_reset_dir", int'(dir), 0);
      repeat (2) step();
      resetn = 1'b1;

      // Randomised key patterns and ticks against the model
      for (int n = 0; n < 300; n++) begin
         mask  = 4'($urandom_range(0, 15));
         hold  = $urandom_range(1, 12);
         key_n = ~mask;
         for (int c = 0; c < hold; c++) begin
            move_tick = ($urandom_range(0, 5) == 0);
            step();
         end
         if ($urandom_range(0, 49) == 0) begin
            move_tick = 1'b0;
            reset_dut();
         end
      end
      move_tick = 1'b0;
      key_n     = 4'hF;
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
